// File: rtl/accum_alu_pkg.sv
// Shared opcode encoding, sequencer state type and opcode width for accum_alu.
package accum_alu_pkg;

  localparam int OPCODE_W = 4;

  // Codes 12-15 are intentionally left unnamed; they decode as illegal.
  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 4'd0,
    OP_AND = 4'd1,
    OP_ADD = 4'd2,
    OP_LDA = 4'd3,
    OP_CMA = 4'd4,
    OP_CIR = 4'd5,
    OP_CIL = 4'd6,
    OP_CLA = 4'd7,
    OP_CLE = 4'd8,
    OP_CME = 4'd9,
    OP_INC = 4'd10,
    OP_MUL = 4'd11
  } op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/accum_alu_mul.sv
// Unsigned shift-add multiplier sequencer: one partial product per cycle, WIDTH steps.
// done is high during the final step cycle; product then holds the complete result.
module accum_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic               busy;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (cnt == LAST_STEP) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Operand/partial registers carry no reset: busy gates every use of them.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == LAST_STEP);

endmodule

// File: rtl/accum_alu.sv
// Accumulator ALU with carry flag E; single-cycle ops plus an optional multi-cycle MUL.
// MUL hardware is built only when ACCUM_ALU_MUL_EN is defined; otherwise op 11 is illegal.
module accum_alu
  import accum_alu_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter logic E_RST = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic [WIDTH-1:0]    dr,
  input  logic                cin,
  output logic [WIDTH-1:0]    ac,
  output logic                e,
  output logic                ac_zero,
  output logic                done,
  output logic                illegal
);

  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] ac_nxt;
  logic             e_nxt;
  logic             illegal_nxt;
  logic             done_nxt;
  logic             mul_start;
  logic             mul_done;

  assign accept  = op_valid && op_ready;
  assign add_sum = {1'b0, ac} + {1'b0, dr} + {{WIDTH{1'b0}}, cin};
  assign inc_sum = {1'b0, ac} + (WIDTH + 1)'(1);
  assign ac_zero = (ac == '0);

`ifdef ACCUM_ALU_MUL_EN
  state_e             state;
  state_e             state_nxt;
  logic [2*WIDTH-1:0] mul_product;

  accum_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (ac),
    .b       (dr),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (mul_start) state_nxt = ST_MUL_BUSY;
      ST_MUL_BUSY: if (mul_done)  state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  assign op_ready = (state == ST_IDLE);
`else
  assign op_ready = 1'b1;
  assign mul_done = 1'b0;
`endif

  always_comb begin
    ac_nxt      = ac;
    e_nxt       = e;
    illegal_nxt = 1'b0;
    mul_start   = 1'b0;
    if (accept) begin
      case (op_e'(op_code))
        OP_NOP: ;
        OP_AND: ac_nxt = ac & dr;
        OP_ADD: {e_nxt, ac_nxt} = add_sum;
        OP_LDA: ac_nxt = dr;
        OP_CMA: ac_nxt = ~ac;
        OP_CIR: {ac_nxt, e_nxt} = {e, ac};
        OP_CIL: {e_nxt, ac_nxt} = {ac, e};
        OP_CLA: ac_nxt = '0;
        OP_CLE: e_nxt = 1'b0;
        OP_CME: e_nxt = ~e;
        OP_INC: {e_nxt, ac_nxt} = inc_sum;
`ifdef ACCUM_ALU_MUL_EN
        OP_MUL: mul_start = 1'b1;
`endif
        default: illegal_nxt = 1'b1;
      endcase
    end
`ifdef ACCUM_ALU_MUL_EN
    // The product lands only on the last step edge, so an aborted MUL leaves ac/e intact.
    if (mul_done) begin
      ac_nxt = mul_product[WIDTH-1:0];
      e_nxt  = |mul_product[2*WIDTH-1:WIDTH];
    end
`endif
  end

  assign done_nxt = (accept && !mul_start) || mul_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac      <= '0;
      e       <= E_RST;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      ac      <= ac_nxt;
      e       <= e_nxt;
      done    <= done_nxt;
      illegal <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_accum_alu.sv
// Self-checking bench for accum_alu (WIDTH=8, E_RST=0): directed cases plus random ops
// against an arithmetic reference model. Follows ACCUM_ALU_MUL_EN for the MUL cases.
module tb_accum_alu;

  localparam int W   = 8;
  localparam int MOD = 256;
`ifdef ACCUM_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [3:0]   op_code = 4'd0;
  logic [W-1:0] dr = '0;
  logic         cin = 1'b0;
  logic [W-1:0] ac;
  logic         e;
  logic         ac_zero;
  logic         done;
  logic         illegal;

  int checks = 0;
  int errors = 0;
  int m_ac = 0;
  int m_e  = 0;

  accum_alu #(.WIDTH(W), .E_RST(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .dr       (dr),
    .cin      (cin),
    .ac       (ac),
    .e        (e),
    .ac_zero  (ac_zero),
    .done     (done),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour: returns whether the op is undefined.
  task automatic model_step(input int op, input int d, input int c, output bit ill);
    int s;
    int ne;
    ill = 1'b0;
    case (op)
      0: ;
      1: m_ac = m_ac & d;
      2: begin s = m_ac + d + c; m_ac = s % MOD; m_e = s / MOD; end
      3: m_ac = d;
      4: m_ac = (MOD - 1) - m_ac;
      5: begin ne = m_ac % 2; m_ac = m_e * (MOD / 2) + m_ac / 2; m_e = ne; end
      6: begin ne = m_ac / (MOD / 2); m_ac = (m_ac * 2) % MOD + m_e; m_e = ne; end
      7: m_ac = 0;
      8: m_e = 0;
      9: m_e = 1 - m_e;
      10: begin s = m_ac + 1; m_ac = s % MOD; m_e = s / MOD; end
      11: begin
        if (MUL_EN) begin
          s = m_ac * d;
          m_ac = s % MOD;
          m_e = (s >= MOD) ? 1 : 0;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ac"}, 32'(ac), 32'(m_ac));
    check({tag, "_e"}, 32'(e), 32'(m_e));
    check({tag, "_zero"}, 32'(ac_zero), 32'(m_ac == 0));
  endtask

  // Issue one op; called right after a sampling point so consecutive calls run back-to-back.
  task automatic issue(input int op, input int d, input int c);
    int n;
    int low;
    bit ill;
    n = 0;
    while (!op_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 40) check("ready_timeout", 32'(op_ready), 32'd1);
    op_valid = 1'b1;
    op_code  = 4'(op);
    dr       = W'(d);
    cin      = 1'(c);
    @(posedge clk); #1;
    model_step(op, d, c, ill);
    if (op == 11 && MUL_EN) begin
      // Keep requesting a different op while busy; it must be ignored.
      op_code = 4'd3;
      dr      = 8'h5A;
      check("mul_done_early", 32'(done), 32'd0);
      low = op_ready ? 0 : 1;
      n = 0;
      while (!done && n < 40) begin
        @(posedge clk); #1;
        n++;
        if (!op_ready) low++;
      end
      check("mul_latency", 32'(n + 1), 32'(W + 1));
      check("mul_ready_low", 32'(low), 32'(W));
      check("mul_illegal", 32'(illegal), 32'd0);
    end else begin
      check("done", 32'(done), 32'd1);
      check("illegal", 32'(illegal), 32'(ill));
    end
    op_valid = 1'b0;
    check_state($sformatf("op%0d", op));
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_ac", 32'(ac), 32'd0);
    check("rst_e", 32'(e), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_zero", 32'(ac_zero), 32'd1);

    // ADD with carry out
    issue(3, 8'hF0, 0);
    issue(2, 8'h20, 1);
    check("add_ac", 32'(ac), 32'h11);
    check("add_e", 32'(e), 32'd1);
    idle_cycle();

    // rotates through E
    issue(3, 8'h80, 0);
    issue(6, 0, 0);
    check("cil_ac", 32'(ac), 32'h01);
    check("cil_e", 32'(e), 32'd1);
    issue(8, 0, 0);
    issue(5, 0, 0);
    check("cir_ac", 32'(ac), 32'h00);
    check("cir_e", 32'(e), 32'd1);
    check("cir_zero", 32'(ac_zero), 32'd1);

    if (MUL_EN) begin
      issue(3, 8'h0C, 0);
      issue(11, 8'h0B, 0);
      check("mul1_ac", 32'(ac), 32'h84);
      check("mul1_e", 32'(e), 32'd0);
      issue(3, 8'h20, 0);
      issue(11, 8'h10, 0);
      check("mul2_ac", 32'(ac), 32'h00);
      check("mul2_e", 32'(e), 32'd1);
    end

    // undefined opcodes leave state alone
    issue(3, 8'h3C, 0);
    issue(15, 8'hFF, 1);
    check("ill15", 32'({illegal, done}), 32'b11);
    check("ill15_ac", 32'(ac), 32'h3C);
    issue(11, 8'h02, 0);
    if (!MUL_EN) check("ill11", 32'({illegal, done}), 32'b11);
    idle_cycle();
    check("ill_pulse", 32'(illegal), 32'd0);

    // back-to-back INC, INC, CMA
    issue(3, 8'hFE, 0);
    issue(10, 0, 0);
    check("inc1_ac", 32'(ac), 32'hFF);
    issue(10, 0, 0);
    check("inc2_ac", 32'(ac), 32'h00);
    check("inc2_e", 32'(e), 32'd1);
    issue(4, 0, 0);
    check("cma_ac", 32'(ac), 32'hFF);
    idle_cycle();

    // random mix, including undefined codes and (if built) MUL
    for (int i = 0; i < 150; i++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // reset in the middle of activity (MUL step 3 when MUL is built)
    issue(3, 8'h0C, 0);
    if (MUL_EN) begin
      op_valid = 1'b1;
      op_code  = 4'd11;
      dr       = 8'h0B;
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
    end else begin
      issue(1, 8'h0F, 0);
    end
    rst_n = 1'b0;
    #1;
    m_ac = 0;
    m_e  = 0;
    check("arst_ac", 32'(ac), 32'd0);
    check("arst_e", 32'(e), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_ready", 32'(op_ready), 32'd1);
    check("arst_done2", 32'(done), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("arst_nodone", 32'(done), 32'd0);
    end
    check_state("arst_post");
    issue(10, 0, 0);
    check("arst_inc", 32'(ac), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
